// File: rtl/register_file_if.sv
// Bundles the operand-read and write-back signals between the MIPS datapath and the register file.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              ready;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2, ready
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2, ready
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one write port, $0 hard-wired
// to zero, and a post-reset sweep that zeroes every entry before writes are accepted.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic       clk,
  input logic       reset,
  register_file_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [ADDR_W-1:0] clr_idx_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              ready;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  // Per-port read priority: not ready, then $0, then same-cycle forwarding, then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rdy,
    input logic [ADDR_W-1:0] idx,
    input logic              we,
    input logic [ADDR_W-1:0] widx,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (!rdy) begin
      res = '0;
    end else if (idx == '0) begin
      res = '0;
    end else if ((BYPASS == 1) && we && (widx == idx)) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        state_d = S_RUN;
      end
    end
  end

  // Reset takes priority over both the sweep and external writes on the same edge.
  always_comb begin
    ready       = (state_q == S_RUN);
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = '0;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_idx_q;
        mem_wdata_d = '0;
      end else if (rf.reg_write && (rf.write_reg != '0)) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = rf.write_reg;
        mem_wdata_d = rf.write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_comb begin
    read_data1 = read_port(ready, rf.read_reg1, rf.reg_write, rf.write_reg,
                           rf.write_data, mem_q[rf.read_reg1]);
    read_data2 = read_port(ready, rf.read_reg2, rf.reg_write, rf.write_reg,
                           rf.write_data, mem_q[rf.read_reg2]);
  end

  assign rf.ready      = ready;
  assign rf.read_data1 = read_data1;
  assign rf.read_data2 = read_data2;

endmodule
